count_cycle_param: RTL and testbench

- Parametrised successor of the fixed 16-bit count/data alignment block.
- Tags each accepted AXI-Stream beat with a per-frame beat index and a final-beat flag, and buffers beat, count and flag together in an internal FIFO.
- Generalised in data width, count width and FIFO depth. Adds limits latched per frame, a frame-start indicator and a FIFO level output.
- Sits ahead of channelizer framing logic, where metadata must stay aligned with samples.

---
 rtl/count_cycle_param_if.sv | 42 ++++
 rtl/count_cycle_param.sv | 147 ++++++++++++++
 tb/tb_count_cycle_param.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_cycle_param_if.sv
// Stream-side bundle for count_cycle_param: input beat handshake, per-frame controls and tagged output.
// frame_cnt is present only when COUNT_CYCLE_FRAME_CNT_EN is defined.
interface count_cycle_param_if #(
   parameter int DATA_WIDTH      = 32,
   parameter int CNT_WIDTH       = 16,
   parameter int FIFO_ADDR_WIDTH = 3
);
   logic                     s_axis_tvalid;
   logic [DATA_WIDTH-1:0]    s_axis_tdata;
   logic                     start_sig;
   logic [CNT_WIDTH-1:0]     cnt_limit;
   logic                     s_axis_tready;
   logic                     m_axis_tvalid;
   logic [DATA_WIDTH-1:0]    m_axis_tdata;
   logic                     m_axis_final_cnt;
   logic                     m_axis_first;
   logic [CNT_WIDTH-1:0]     count;
   logic [FIFO_ADDR_WIDTH:0] fifo_level;
   logic                     m_axis_tready;
`ifdef COUNT_CYCLE_FRAME_CNT_EN
   logic [15:0]              frame_cnt;
`endif

   // Block side: consumes the input beat, produces the tagged output.
   modport slave (
`ifdef COUNT_CYCLE_FRAME_CNT_EN
      output frame_cnt,
`endif
      input  s_axis_tvalid, s_axis_tdata, start_sig, cnt_limit, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_final_cnt,
      output m_axis_first, count, fifo_level
   );

   modport master (
`ifdef COUNT_CYCLE_FRAME_CNT_EN
      input  frame_cnt,
`endif
      output s_axis_tvalid, s_axis_tdata, start_sig, cnt_limit, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_final_cnt,
      input  m_axis_first, count, fifo_level
   );
endinterface

// File: rtl/count_cycle_param.sv
// Tags each accepted beat with its index within the frame plus first/final flags and buffers it in a FWFT FIFO.
// Optional macro COUNT_CYCLE_FRAME_CNT_EN adds a 16-bit frame counter carried with every beat.
module count_cycle_param #(
   parameter int DATA_WIDTH      = 32,
   parameter int CNT_WIDTH       = 16,
   parameter int FIFO_ADDR_WIDTH = 3
) (
   input  logic               clk,
   input  logic               async_reset_n,
   count_cycle_param_if.slave io_axis
);
   localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
   localparam int LW    = FIFO_ADDR_WIDTH + 1;
   localparam logic [LW:0] READY_MAX = (LW + 1)'(DEPTH - 3);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [CNT_WIDTH-1:0]  cnt;
      logic                  fin;
      logic                  fst;
`ifdef COUNT_CYCLE_FRAME_CNT_EN
      logic [15:0]           frame;
`endif
   } word_t;

   logic                  r_ready;
   logic                  w_take;
   logic                  r_vld_p0;
   logic [DATA_WIDTH-1:0] r_data_p0;
   logic                  r_start_p0;
   logic [CNT_WIDTH-1:0]  r_lim_p0;
   logic                  r_startup;
   logic                  r_prev_fin;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [CNT_WIDTH-1:0]  r_lim;
   logic                  w_zero;
   logic [CNT_WIDTH-1:0]  w_idx;
   logic [CNT_WIDTH-1:0]  w_lim;
   logic                  w_fin;
`ifdef COUNT_CYCLE_FRAME_CNT_EN
   logic [15:0]           r_frame;
   logic                  r_frame_seen;
   logic [15:0]           w_frame;
`endif
   logic                  r_vld_p1;
   word_t                 r_word_p1;
   word_t                 r_mem [0:DEPTH-1];
   logic [LW-1:0]         r_wr_ptr;
   logic [LW-1:0]         r_rd_ptr;
   logic [LW-1:0]         w_level;
   logic [LW:0]           w_pending;
   logic                  w_valid;
   logic                  w_rd;
   word_t                 w_head;

   assign w_take    = io_axis.s_axis_tvalid & r_ready;
   assign w_level   = r_wr_ptr - r_rd_ptr;
   assign w_valid   = (w_level != '0);
   assign w_rd      = w_valid & io_axis.m_axis_tready;
   // Everything already committed: stored words plus both pipeline stages.
   assign w_pending = {1'b0, w_level} + (LW + 1)'(r_vld_p0) + (LW + 1)'(r_vld_p1);

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         r_ready  <= 1'b0;
         r_vld_p0 <= 1'b0;
         r_vld_p1 <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_ready  <= (w_pending <= READY_MAX);
         r_vld_p0 <= w_take;
         r_vld_p1 <= r_vld_p0;
         if (r_vld_p1) r_wr_ptr <= r_wr_ptr + LW'(1);
         if (w_rd)     r_rd_ptr <= r_rd_ptr + LW'(1);
      end
   end

   // Stage p0: capture the accepted beat and its frame controls.
   always_ff @(posedge clk) begin
      if (w_take) begin
         r_data_p0  <= io_axis.s_axis_tdata;
         r_start_p0 <= io_axis.start_sig;
         r_lim_p0   <= io_axis.cnt_limit;
      end
   end

   // Index 0 re-latches the limit, so final is judged against the new limit on that same beat.
   always_comb begin
      w_zero  = r_startup | r_start_p0 | r_prev_fin;
      w_idx   = w_zero ? '0 : r_cnt + CNT_WIDTH'(1);
      w_lim   = w_zero ? r_lim_p0 : r_lim;
      w_fin   = (w_idx == w_lim);
`ifdef COUNT_CYCLE_FRAME_CNT_EN
      w_frame = (w_zero & r_frame_seen) ? r_frame + 16'd1 : r_frame;
`endif
   end

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         r_startup    <= 1'b1;
         r_prev_fin   <= 1'b0;
         r_cnt        <= '0;
         r_lim        <= '0;
`ifdef COUNT_CYCLE_FRAME_CNT_EN
         r_frame      <= '0;
         r_frame_seen <= 1'b0;
`endif
      end else if (r_vld_p0) begin
         r_startup    <= 1'b0;
         r_prev_fin   <= w_fin;
         r_cnt        <= w_idx;
         r_lim        <= w_lim;
`ifdef COUNT_CYCLE_FRAME_CNT_EN
         r_frame      <= w_frame;
         if (w_zero) r_frame_seen <= 1'b1;
`endif
      end
   end

   // Stage p1: tagged word, written into the FIFO on the following edge.
   always_ff @(posedge clk) begin
      if (r_vld_p0) begin
         r_word_p1.data  <= r_data_p0;
         r_word_p1.cnt   <= w_idx;
         r_word_p1.fin   <= w_fin;
         r_word_p1.fst   <= (w_idx == '0);
`ifdef COUNT_CYCLE_FRAME_CNT_EN
         r_word_p1.frame <= w_frame;
`endif
      end
      if (r_vld_p1) r_mem[r_wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= r_word_p1;
   end

   // FIFO head drives the outputs directly; zeroed while empty so reset shows clean metadata.
   assign w_head                   = r_mem[r_rd_ptr[FIFO_ADDR_WIDTH-1:0]];
   assign io_axis.s_axis_tready    = r_ready;
   assign io_axis.m_axis_tvalid    = w_valid;
   assign io_axis.fifo_level       = w_level;
   assign io_axis.m_axis_tdata     = w_valid ? w_head.data : '0;
   assign io_axis.count            = w_valid ? w_head.cnt  : '0;
   assign io_axis.m_axis_final_cnt = w_valid & w_head.fin;
   assign io_axis.m_axis_first     = w_valid & w_head.fst;
`ifdef COUNT_CYCLE_FRAME_CNT_EN
   assign io_axis.frame_cnt        = w_valid ? w_head.frame : '0;
`endif
endmodule

// File: tb/tb_count_cycle_param.sv
// Randomised and directed bench for count_cycle_param with a beat-level scoreboard model.
// Builds with or without COUNT_CYCLE_FRAME_CNT_EN.
module tb_count_cycle_param;
   localparam int DW    = 32;
   localparam int CW    = 16;
   localparam int AW    = 3;
   localparam int DEPTH = 2 ** AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   count_cycle_param_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_ADDR_WIDTH(AW)) bus ();

   count_cycle_param #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .async_reset_n(rst_n),
      .io_axis      (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: one entry per accepted beat, tagged from the frame rules.
   typedef struct {
      logic [DW-1:0] data;
      int            cnt;
      bit            fin;
      bit            fst;
      int            frame;
      int            acc_cyc;
      bit            seen;
   } exp_t;

   exp_t exp_q[$];
   bit   m_startup;
   int   m_prev;
   bit   m_prev_fin;
   int   m_lim;
   int   m_frame;
   bit   m_fseen;
   int   cyc = 0;

   function automatic void model_reset();
      exp_q.delete();
      m_startup  = 1'b1;
      m_prev     = 0;
      m_prev_fin = 1'b0;
      m_lim      = 0;
      m_frame    = 0;
      m_fseen    = 1'b0;
   endfunction

   function automatic void model_accept(input logic [DW-1:0] d, input bit st, input int lim);
      exp_t e;
      int   idx;
      if (m_startup || st || m_prev_fin) begin
         idx   = 0;
         m_lim = lim;
         if (m_fseen) m_frame = (m_frame + 1) % 65536;
         m_fseen = 1'b1;
      end else begin
         idx = m_prev + 1;
      end
      m_startup  = 1'b0;
      m_prev     = idx;
      m_prev_fin = (idx == m_lim);
      e = '{data: d, cnt: idx, fin: (idx == m_lim), fst: (idx == 0),
            frame: m_frame, acc_cyc: cyc, seen: 1'b0};
      exp_q.push_back(e);
   endfunction

   int peak = 0;
   int peak_all = 0;
   bit rdy_dropped = 1'b0;
   int first_lat = -1;
   int log_cnt[$];
   bit log_fin[$];
   bit log_fst[$];
   int e_cnt[$];
   bit e_fin[$];
   bit e_fst[$];

   // Monitor samples on the falling edge, where inputs and outputs are both settled.
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (int'(bus.fifo_level) > peak)     peak     = int'(bus.fifo_level);
         if (int'(bus.fifo_level) > peak_all) peak_all = int'(bus.fifo_level);
         if (!bus.s_axis_tready) rdy_dropped = 1'b1;
         if (bus.m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               if (!exp_q[0].seen) begin
                  exp_q[0].seen = 1'b1;
                  check("latency_min", 64'(cyc - exp_q[0].acc_cyc >= 3), 1);
                  if (first_lat < 0) first_lat = cyc - exp_q[0].acc_cyc;
               end
               check("tdata", bus.m_axis_tdata, exp_q[0].data);
               check("count", bus.count, exp_q[0].cnt);
               check("final", bus.m_axis_final_cnt, exp_q[0].fin);
               check("first", bus.m_axis_first, exp_q[0].fst);
`ifdef COUNT_CYCLE_FRAME_CNT_EN
               check("frame_cnt", bus.frame_cnt, exp_q[0].frame);
`endif
               if (bus.m_axis_tready) begin
                  log_cnt.push_back(int'(bus.count));
                  log_fin.push_back(bus.m_axis_final_cnt);
                  log_fst.push_back(bus.m_axis_first);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (bus.s_axis_tvalid && bus.s_axis_tready)
            model_accept(bus.s_axis_tdata, bus.start_sig, int'(bus.cnt_limit));
      end
   end

   task automatic send(input logic [DW-1:0] d, input bit st, input int lim);
      int budget = 200;
      bit acc    = 1'b0;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = d;
      bus.start_sig     = st;
      bus.cnt_limit     = CW'(lim);
      while (!acc && budget > 0) begin
         @(negedge clk);
         acc = bus.s_axis_tready;
         @(posedge clk);
         #1;
         budget--;
      end
      if (!acc) check("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      bus.s_axis_tvalid = 1'b0;
      bus.start_sig     = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int budget = 300;
      bus.s_axis_tvalid = 1'b0;
      bus.start_sig     = 1'b0;
      bus.m_axis_tready = 1'b1;
      while ((exp_q.size() != 0 || bus.m_axis_tvalid) && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic clear_log();
      log_cnt.delete();
      log_fin.delete();
      log_fst.delete();
   endtask

   task automatic compare_log(input string tag);
      check({tag, "_len"}, log_cnt.size(), e_cnt.size());
      for (int i = 0; i < e_cnt.size() && i < log_cnt.size(); i++) begin
         check($sformatf("%s_cnt%0d", tag, i), log_cnt[i], e_cnt[i]);
         check($sformatf("%s_fin%0d", tag, i), log_fin[i], e_fin[i]);
         check($sformatf("%s_fst%0d", tag, i), log_fst[i], e_fst[i]);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
      check({tag, "_tready"}, bus.s_axis_tready, 0);
      check({tag, "_level"}, bus.fifo_level, 0);
      check({tag, "_count"}, bus.count, 0);
      check({tag, "_final"}, bus.m_axis_final_cnt, 0);
      check({tag, "_first"}, bus.m_axis_first, 0);
`ifdef COUNT_CYCLE_FRAME_CNT_EN
      check({tag, "_frame"}, bus.frame_cnt, 0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit acc;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.start_sig     = 1'b0;
      bus.cnt_limit     = '0;
      bus.m_axis_tready = 1'b1;
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      check("ready_at_release", bus.s_axis_tready, 0);
      @(posedge clk);
      #1;
      check("ready_after_release", bus.s_axis_tready, 1);

      // Limit 3, ten beats straight after reset.
      clear_log();
      first_lat = -1;
      for (int i = 0; i < 10; i++) send($urandom, 1'b0, 3);
      drain();
      check("t1_first_latency", first_lat, 3);
      e_cnt = {0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
      e_fin = {0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
      e_fst = {1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
      compare_log("t1");

      // Limit 5, restart on beat 3.
      clear_log();
      for (int i = 0; i < 10; i++) send($urandom, (i == 0 || i == 3), 5);
      drain();
      e_cnt = {0, 1, 2, 0, 1, 2, 3, 4, 5, 0};
      e_fin = {0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      e_fst = {1, 0, 0, 1, 0, 0, 0, 0, 0, 1};
      compare_log("t2");

      // Limit changes 7 -> 2 mid-frame; applies from the next frame.
      clear_log();
      for (int i = 0; i < 12; i++) send($urandom, (i == 0), (i < 4) ? 7 : 2);
      drain();
      e_cnt = {0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 0};
      e_fin = {0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
      e_fst = {1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
      compare_log("t3");

      // Limit 0: every beat is a one-beat frame.
      clear_log();
      for (int i = 0; i < 6; i++) send($urandom, (i == 0), 0);
      drain();
      e_cnt = {0, 0, 0, 0, 0, 0};
      e_fin = {1, 1, 1, 1, 1, 1};
      e_fst = {1, 1, 1, 1, 1, 1};
      compare_log("t5");

      // Output stalled for 20 cycles under continuous input.
      bus.m_axis_tready = 1'b0;
      peak        = 0;
      rdy_dropped = 1'b0;
      bus.start_sig     = 1'b0;
      bus.cnt_limit     = CW'(4);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = $urandom;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         acc = bus.s_axis_tready;
         @(posedge clk);
         #1;
         if (acc) bus.s_axis_tdata = $urandom;
      end
      bus.s_axis_tvalid = 1'b0;
      idle(4);
      check("bp_ready_dropped", rdy_dropped, 1);
      check("bp_peak_le_depth", 64'(peak <= DEPTH), 1);
      check("bp_peak_near_full", 64'(peak >= DEPTH - 1), 1);
      drain();

      // Randomised traffic with random output backpressure.
      for (int c = 0; c < 400; c++) begin
         bus.s_axis_tvalid = ($urandom_range(0, 3) != 0);
         bus.s_axis_tdata  = $urandom;
         bus.start_sig     = ($urandom_range(0, 9) == 0);
         bus.cnt_limit     = ($urandom_range(0, 15) == 0) ? {CW{1'b1}} : CW'($urandom_range(0, 5));
         bus.m_axis_tready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      drain();

      // Reset with four beats buffered mid-frame.
      bus.m_axis_tready = 1'b0;
      for (int i = 0; i < 4; i++) send($urandom, (i == 0), 9);
      idle(4);
      check("pre_reset_level", bus.fifo_level, 4);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.m_axis_tready = 1'b1;
      check("midrst_ready_after", bus.s_axis_tready, 1);
      clear_log();
      for (int i = 0; i < 5; i++) send($urandom, 1'b0, 3);
      drain();
      e_cnt = {0, 1, 2, 3, 0};
      e_fin = {0, 0, 0, 1, 0};
      e_fst = {1, 0, 0, 0, 1};
      compare_log("midrst");

      check("peak_all_le_depth", 64'(peak_all <= DEPTH), 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
